// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment display path: special digit codes,
// converter state encoding and counter sizing.
package seg7_pkg;

    localparam logic [3:0] DIG_MINUS = 4'hA;
    localparam logic [3:0] DIG_BLANK = 4'hF;

    localparam int BIN_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SHIFT  = 2'd2,
        FORMAT = 2'd3
    } state_t;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble digit correction: a BCD nibble of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-packed-BCD converter (one bit per clock) feeding the
// 8-digit seven-segment driver, with blanking, minus sign and overflow marking.
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int WIDTH    = BIN_WIDTH,
    parameter int DIGITS   = 8,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      value,
    input  logic                  is_signed,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int           CW      = cnt_width(WIDTH);
    localparam int           BW      = 4 * DIGITS;
    localparam logic [63:0]  MAX_POS = (64'd10 ** DIGITS) - 64'd1;
    localparam logic [63:0]  MAX_NEG = (64'd10 ** (DIGITS - 1)) - 64'd1;
    localparam logic [BW-1:0] RST_BCD = BLANK_LZ ? {{(DIGITS-1){DIG_BLANK}}, 4'h0} : '0;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] mag;
    logic [63:0]      mag_ext;
    logic [BW-1:0]    acc, acc_adj;
    logic             sgn, neg, ovf_pend;
    logic             neg_ld, ovf_ld;

    function automatic logic [BW-1:0] fmt(input logic [BW-1:0] d,
                                          input logic is_neg,
                                          input logic is_ovf);
        logic [BW-1:0] r;
        int            msd;
        r   = d;
        msd = 0;
        if (is_ovf) begin
            r = {DIGITS{DIG_MINUS}};
        end else begin
            for (int i = 0; i < DIGITS; i++)
                if (d[4*i +: 4] != 4'h0) msd = i;
            if (BLANK_LZ) begin
                for (int i = 0; i < DIGITS; i++)
                    if (i > msd) r[4*i +: 4] = DIG_BLANK;
                if (is_neg && d != '0 && msd < DIGITS - 1)
                    r[4*(msd+1) +: 4] = DIG_MINUS;
            end else if (is_neg && d != '0) begin
                r[BW-1 -: 4] = DIG_MINUS;
            end
        end
        return r;
    endfunction

    // Magnitude and range check, evaluated while in LOAD on the captured operand
    always_comb begin
        neg_ld  = sgn & sh[WIDTH-1];
        mag     = neg_ld ? -sh : sh;
        mag_ext = 64'(mag);
        ovf_ld  = neg_ld ? (mag_ext > MAX_NEG) : (mag_ext > MAX_POS);
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (acc[4*g +: 4]),
            .dout (acc_adj[4*g +: 4])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = SHIFT;
            SHIFT:   if (cnt == CW'(WIDTH - 1)) state_nxt = FORMAT;
            FORMAT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            done <= 1'b0;
            bcd  <= RST_BCD;
            ovf  <= 1'b0;
        end else begin
            done <= (state == FORMAT);
            if (state == LOAD)       cnt <= '0;
            else if (state == SHIFT) cnt <= cnt + 1'b1;
            if (state == FORMAT) begin
                bcd <= fmt(acc, neg, ovf_pend);
                ovf <= ovf_pend;
            end
        end
    end

    // Operand and accumulator registers carry no reset; control gates their use
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (start) begin
                    sh  <= value;
                    sgn <= is_signed;
                end
            end
            LOAD: begin
                sh       <= mag;
                neg      <= neg_ld;
                ovf_pend <= ovf_ld;
                acc      <= '0;
            end
            SHIFT:   {acc, sh} <= {acc_adj[BW-2:0], sh, 1'b0};
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Randomized and directed bench for bin2bcd_seq, with blanking on and off,
// against an arithmetic reference model.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst, start, is_signed;
    logic [31:0] value;
    logic        busy1, done1, ovf1, busy0, done0, ovf0;
    logic [31:0] bcd1, bcd0;
    logic [31:0] prev1, prev0;
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.WIDTH(32), .DIGITS(8), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .value(value), .is_signed(is_signed),
        .busy(busy1), .done(done1), .bcd(bcd1), .ovf(ovf1)
    );

    bin2bcd_seq #(.WIDTH(32), .DIGITS(8), .BLANK_LZ(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .value(value), .is_signed(is_signed),
        .busy(busy0), .done(done0), .bcd(bcd0), .ovf(ovf0)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] model(input logic [31:0] v, input bit s,
                                          input bit blank, output bit ov);
        bit               neg;
        longint unsigned  mag, t;
        int               nd;
        logic [31:0]      r;
        neg = s && v[31];
        mag = neg ? (64'h1_0000_0000 - {32'h0, v}) : {32'h0, v};
        ov  = neg ? (mag > 64'd9999999) : (mag > 64'd99999999);
        if (ov) return 32'hAAAAAAAA;
        nd = 1;
        t  = mag / 10;
        while (t != 0) begin nd++; t = t / 10; end
        r = blank ? 32'hFFFFFFFF : 32'h0;
        t = mag;
        for (int i = 0; i < 8; i++) begin
            if (i < nd) r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        if (neg && mag != 0) begin
            if (blank) r[4*nd +: 4] = 4'hA;
            else       r[31:28]     = 4'hA;
        end
        return r;
    endfunction

    task automatic convert(input logic [31:0] v, input bit s, input bit noise);
        logic [31:0] e1, e0;
        bit          ov1, ov0, bsy_ok, stable_ok;
        int          lat;
        e1 = model(v, s, 1'b1, ov1);
        e0 = model(v, s, 1'b0, ov0);
        @(negedge clk);
        value = v; is_signed = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; bsy_ok = 1'b1; stable_ok = 1'b1;
        while (!done1 && lat < 100) begin
            if (!busy1 || !busy0) bsy_ok = 1'b0;
            if (bcd1 !== prev1 || bcd0 !== prev0) stable_ok = 1'b0;
            if (noise) begin
                start = (lat >= 2 && lat <= 30 && lat % 4 == 0);
                if (start) begin value = $urandom; is_signed = 1'($urandom); end
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        chk("latency", lat, 34);
        chk("busy_during", bsy_ok, 1);
        chk("bcd_stable", stable_ok, 1);
        chk("busy_at_done", busy1, 0);
        chk("done0", done0, 1);
        chk("bcd_blank", bcd1, e1);
        chk("ovf_blank", ovf1, ov1);
        chk("bcd_noblank", bcd0, e0);
        chk("ovf_noblank", ovf0, ov0);
        prev1 = e1; prev0 = e0;
        @(posedge clk); #1;
        chk("done_pulse", done1, 0);
    endtask

    initial begin
        int          d_at[$];
        int          cyc;
        logic [31:0] v;
        bit          s, ovx;
        rst = 1'b1; start = 1'b0; value = '0; is_signed = 1'b0;
        #12;
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_ovf", ovf1, 0);
        chk("rst_bcd_blank", bcd1, 32'hFFFFFFF0);
        chk("rst_bcd_noblank", bcd0, 32'h0);
        prev1 = 32'hFFFFFFF0; prev0 = 32'h0;
        @(negedge clk); rst = 1'b0;

        convert(32'd12345678, 1'b0, 1'b0);
        convert(32'd0,        1'b0, 1'b0);
        convert(32'd907,      1'b0, 1'b0);
        convert(32'hFFFFFFD6, 1'b1, 1'b0);
        convert(32'hFF676981, 1'b1, 1'b0);
        convert(32'd100000000, 1'b0, 1'b0);
        convert(-32'sd10000000, 1'b1, 1'b0);
        convert(32'h80000000, 1'b1, 1'b0);
        convert(32'h80000000, 1'b0, 1'b0);
        convert(32'd99999999, 1'b0, 1'b0);
        convert(32'd0,        1'b1, 1'b0);
        convert(32'd4321,     1'b0, 1'b1);

        for (int k = 0; k < 24; k++) begin
            case ($urandom_range(0, 3))
                0: begin v = $urandom; s = 1'($urandom); end
                1: begin v = $urandom_range(0, 99999999); s = 1'b0; end
                2: begin v = -$urandom_range(0, 9999999); s = 1'b1; end
                default: begin v = $urandom_range(0, 999); s = 1'($urandom); end
            endcase
            convert(v, s, (k % 5) == 0);
        end

        // start held high: three back-to-back conversions
        @(negedge clk);
        value = 32'd31415926; is_signed = 1'b0; start = 1'b1;
        cyc = 0;
        while (d_at.size() < 3 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (done1) begin
                d_at.push_back(cyc);
                chk("hold_bcd", bcd1, model(32'd31415926, 1'b0, 1'b1, ovx));
                if (d_at.size() == 3) start = 1'b0;
            end
        end
        start = 1'b0;
        chk("hold_count", d_at.size(), 3);
        if (d_at.size() == 3) begin
            chk("hold_first", d_at[0], 35);
            chk("hold_period1", d_at[1] - d_at[0], 35);
            chk("hold_period2", d_at[2] - d_at[1], 35);
        end
        prev1 = model(32'd31415926, 1'b0, 1'b1, ovx);
        prev0 = model(32'd31415926, 1'b0, 1'b0, ovx);
        @(posedge clk); #1;
        chk("hold_idle", busy1, 0);

        // asynchronous reset partway through a conversion
        @(negedge clk);
        value = 32'd777; is_signed = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_busy", busy1, 0);
        chk("arst_bcd_blank", bcd1, 32'hFFFFFFF0);
        chk("arst_bcd_noblank", bcd0, 32'h0);
        chk("arst_ovf", ovf1, 0);
        cyc = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done1 || done0) cyc++;
        end
        chk("arst_no_done", cyc, 0);
        @(negedge clk); rst = 1'b0;
        prev1 = 32'hFFFFFFF0; prev0 = 32'h0;
        convert(32'd123, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential binary-to-packed-BCD converter. It sits directly upstream of the 8-digit seven-segment driver and produces the 32-bit nibble word that driver scans. The conversion uses iterative shift-add-3 (double dabble), one bit per clock. After conversion it formats the result:
- leading-zero blanking (nibble 0xF, which the driver shows as all segments off)
- minus sign (nibble 0xA, which the driver shows as '-')
- overflow indication

Parameters:
- WIDTH, 32, input value width in bits; also sets conversion latency.
- DIGITS, 8, number of BCD nibbles output; bcd width is 4*DIGITS.
- BLANK_LZ, 1, 1 = replace leading zero digits with 0xF; 0 = keep zeros.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a conversion; sampled only in IDLE.
- value  input  WIDTH  binary operand, captured on the edge that accepts start.
- is_signed  input  1  treat value as two's complement; captured with value.
- busy  output  1  high while a conversion is in progress.
- done  output  1  single-cycle pulse when bcd/ovf are updated.
- bcd  output  4*DIGITS  formatted digit word; nibble i is display digit i (digit 0 rightmost); held between conversions.
- ovf  output  1  last result was out of range; held with bcd.

Behaviour:
- Clocking and reset:
  - Single clock domain on clk. rst is asynchronous and active-high; it forces the block to its reset state immediately, independent of clk.
- Reset state:
  - state=IDLE, busy=0, done=0, ovf=0.
  - bcd = formatted result of converting 0: BLANK_LZ=1 gives 0xFFFFFFF0; BLANK_LZ=0 gives 0x00000000.
- States: IDLE -> LOAD -> SHIFT -> FORMAT -> IDLE.
- IDLE:
  - start=1 at an edge: capture value and is_signed, set busy=1, go to LOAD.
- LOAD (1 cycle):
  - neg = is_signed & value[WIDTH-1]; mag = neg ? -value : value (WIDTH-bit unsigned).
  - Range check: overflow if mag > 10^DIGITS-1 (when neg=0) or mag > 10^(DIGITS-1)-1 (when neg=1).
  - Clear the BCD accumulator, load mag into the shift register, set bit counter=0, go to SHIFT.
- SHIFT (exactly WIDTH cycles):
  - Each cycle, every BCD nibble >=5 gets +3, then the combined {bcd_acc, mag_shift} register shifts left 1.
  - The counter increments each cycle; on counter==WIDTH-1, go to FORMAT.
- FORMAT (1 cycle), on exit:
  - If overflow: bcd = all nibbles 0xA; ovf=1.
  - Else, with msd = index of the most significant nonzero digit (0 if the value is zero):
    - BLANK_LZ=1: nibbles above msd become 0xF. If neg, nibble msd+1 becomes 0xA.
    - BLANK_LZ=0: zeros are kept. If neg, nibble DIGITS-1 becomes 0xA.
    - ovf=0.
  - done=1 for one cycle, busy=0, go to IDLE.
- Latency: done rises WIDTH+2 clocks after the accepting edge (34 for WIDTH=32). busy and done are never high together.
- Handshake and boundary conditions:
  - start while busy is ignored; no queueing.
  - start in the same cycle as done is accepted, so back-to-back conversions have a period of WIDTH+3 cycles.
  - bcd and ovf change only on the edge that raises done; they are stable otherwise.
  - Unsigned input with value[WIDTH-1]=1 is handled as a positive magnitude.
  - Most-negative input (0x80000000, signed) negates to itself as unsigned 2^31, which overflows: all-0xA output.
  - Value 0: single '0' in digit 0; the sign is never shown for zero.
  - rst mid-conversion aborts it: no done pulse, bcd and ovf return to their reset values.
- Width rule: the BCD accumulator is 4*DIGITS bits. Any value passing the range check fits without carry out of the top nibble.

Decomposition:
- Package seg7_pkg holds:
  - DIG_MINUS=4'hA and DIG_BLANK=4'hF (shared with the display driver's decoder);
  - the state encoding localparams (IDLE, LOAD, SHIFT, FORMAT);
  - the bit-counter width, $clog2(WIDTH).
- One sub-module, bcd_digit_adj: combinational, 4 bits in, 4 bits out, add 3 when the input is >=5. It is instantiated DIGITS times in a generate loop.
- Range-check constants are computed as parameter-level localparams.

Test Plan:
1. value=12345678 (decimal), is_signed=0, start pulse -> done exactly 34 cycles later; bcd=0x12345678; ovf=0; busy high for the 34 cycles before done.
2. value=0 with BLANK_LZ=1 -> bcd=0xFFFFFFF0. value=907 -> 0xFFFFF907. With BLANK_LZ=0, value=907 -> 0x00000907.
3. is_signed=1, value=0xFFFFFFD6 (-42) -> bcd=0xFFFFFA42. value=0xFF676981 (-9999999) -> 0xA9999999, ovf=0.
4. Overflow cases, each giving bcd=0xAAAAAAAA and ovf=1:
   - value=100000000, unsigned;
   - value=-10000000, signed;
   - value=0x80000000, signed.
5. Handshake:
   - start held high continuously for 3 conversions -> done every 35 cycles.
   - Extra start pulses during busy -> ignored; bcd unchanged until the next done.
6. Assert rst asynchronously (between edges) at cycle 10 of a conversion -> busy=0 and bcd=0xFFFFFFF0 immediately, no done pulse. After release, a new start converts normally.
